// File: rtl/sec32_pkg.sv
// sec32_pkg
//   Shared definitions for the 32-bit SEC encoder/decoder pair.
//   codeword_t   : {cen, check[7:0], data[31:0]} as presented to the decoder
//   SEC32_CMASK  : per-check-bit data selection masks (c[k] = ^(d & SEC32_CMASK[k]))
//   sec32_check  : reference data -> check computation
package sec32_pkg;

    typedef struct packed {
        logic        cen;
        logic [7:0]  check;
        logic [31:0] data;
    } codeword_t;

    // Bit k of mask j set means data bit k participates in check bit j.
    localparam logic [31:0] SEC32_CMASK [0:7] = '{
        32'h00FF_1111,  // c0: 0,4,8,12,16-23
        32'hFF00_2222,  // c1: 1,5,9,13,24-31
        32'h0F0F_4444,  // c2: 2,6,10,14,16-19,24-27
        32'hF0F0_8888,  // c3: 3,7,11,15,20-23,28-31
        32'h1111_00FF,  // c4: 0-7,16,20,24,28
        32'h2222_FF00,  // c5: 8-15,17,21,25,29
        32'h4444_0F0F,  // c6: 0-3,8-11,18,22,26,30
        32'h8888_F0F0   // c7: 4-7,12-15,19,23,27,31
    };

    function automatic logic [7:0] sec32_check(input logic [31:0] data);
        logic [7:0] c;
        c = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            c[k] = ^(data & SEC32_CMASK[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/sec32_check_encoder_parity_gen.sv
// sec32_parity_gen
//   Purely combinational check-bit generator.
//   data_i  [31:0] : data word
//   check_o [7:0]  : check bits, c[k] = XOR of data bits selected by SEC32_CMASK[k]
module sec32_parity_gen
    import sec32_pkg::*;
(
    input  logic [31:0] data_i,
    output logic [7:0]  check_o
);

    always_comb begin
        check_o = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            check_o[k] = ^(data_i & SEC32_CMASK[k]);
        end
    end

endmodule

// File: rtl/sec32_check_encoder.sv
// sec32_check_encoder
//   Two-stage encoder for the 32-bit SEC decoder: S1 registers the input word,
//   S2 registers data plus computed check bits (optionally XORed with a one-shot
//   injection mask). Valid/ready on both sides, no skid buffer.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake, in_data [31:0]
//   out_valid/out_ready   : output handshake
//   out_data/out_check    : codeword data [31:0] and check [7:0]; out_cen = out_valid
//   inj_arm/inj_mask      : arm a one-shot {check,data} XOR mask
//   inj_armed             : mask armed, not yet applied
//   out_words/inj_words   : transferred codewords / transferred injected codewords
module sec32_check_encoder
    import sec32_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter bit          INJ_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_check,
    output logic             out_cen,
    input  logic             inj_arm,
    input  logic [39:0]      inj_mask,
    output logic             inj_armed,
    output logic [CNT_W-1:0] out_words,
    output logic [CNT_W-1:0] inj_words
);

    logic             s1_v_q, s1_v_d;
    logic [31:0]      s1_data_q, s1_data_d;
    logic             s2_v_q, s2_v_d;
    logic [31:0]      s2_data_q, s2_data_d;
    logic [7:0]       s2_check_q, s2_check_d;
    logic             s2_inj_q, s2_inj_d;
    logic             armed_q, armed_d;
    logic [39:0]      mask_q, mask_d;
    logic [CNT_W-1:0] out_words_q, out_words_d;
    logic [CNT_W-1:0] inj_words_q, inj_words_d;

    logic             s2_adv;
    logic             move;
    logic             out_fire;
    logic [7:0]       calc_check;
    logic [39:0]      apply_mask;
    codeword_t        out_cw;

    sec32_parity_gen u_parity (
        .data_i  (s1_data_q),
        .check_o (calc_check)
    );

    always_comb begin
        s2_adv     = !s2_v_q | out_ready;
        in_ready   = !s1_v_q | s2_adv;
        move       = s1_v_q & s2_adv;
        out_fire   = s2_v_q & out_ready;
        // A mask armed in the same cycle as a move only reaches the next word,
        // because the move uses the registered armed state.
        apply_mask = (INJ_EN && armed_q) ? mask_q : '0;

        s1_v_d      = s1_v_q;
        s1_data_d   = s1_data_q;
        s2_v_d      = s2_v_q;
        s2_data_d   = s2_data_q;
        s2_check_d  = s2_check_q;
        s2_inj_d    = s2_inj_q;
        armed_d     = armed_q;
        mask_d      = mask_q;
        out_words_d = out_words_q;
        inj_words_d = inj_words_q;

        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
            end
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                {s2_check_d, s2_data_d} = {calc_check, s1_data_q} ^ apply_mask;
                s2_inj_d                = |apply_mask;
            end
        end

        if (INJ_EN && inj_arm) begin
            armed_d = 1'b1;
            mask_d  = inj_mask;
        end else if (move) begin
            armed_d = 1'b0;
        end

        if (out_fire) begin
            out_words_d = out_words_q + CNT_W'(1);
            if (s2_inj_q) begin
                inj_words_d = inj_words_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_data_q   <= '0;
            s2_v_q      <= 1'b0;
            s2_data_q   <= '0;
            s2_check_q  <= '0;
            s2_inj_q    <= 1'b0;
            armed_q     <= 1'b0;
            mask_q      <= '0;
            out_words_q <= '0;
            inj_words_q <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_data_q   <= s1_data_d;
            s2_v_q      <= s2_v_d;
            s2_data_q   <= s2_data_d;
            s2_check_q  <= s2_check_d;
            s2_inj_q    <= s2_inj_d;
            armed_q     <= armed_d;
            mask_q      <= mask_d;
            out_words_q <= out_words_d;
            inj_words_q <= inj_words_d;
        end
    end

    always_comb begin
        out_cw.cen   = s2_v_q;
        out_cw.check = s2_check_q;
        out_cw.data  = s2_data_q;
    end

    assign out_valid = s2_v_q;
    assign out_cen   = out_cw.cen;
    assign out_check = out_cw.check;
    assign out_data  = out_cw.data;
    assign inj_armed = armed_q;
    assign out_words = out_words_q;
    assign inj_words = inj_words_q;

endmodule

// File: tb/tb_sec32_check_encoder.sv
// tb_sec32_check_encoder
//   Directed bench for sec32_check_encoder. Two instances share all inputs:
//   dut (injection enabled) and dut0 (INJ_EN=0). Inputs change on the falling
//   edge; outputs are observed shortly after it.
module tb_sec32_check_encoder;
    import sec32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        inj_arm;
    logic [39:0] inj_mask;

    logic        in_ready, out_valid, out_cen, inj_armed;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic [15:0] out_words, inj_words;

    logic        in_ready0, out_valid0, out_cen0, inj_armed0;
    logic [31:0] out_data0;
    logic [7:0]  out_check0;
    logic [15:0] out_words0, inj_words0;

    always #5 clk = ~clk;

    sec32_check_encoder #(.CNT_W(16), .INJ_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_check(out_check), .out_cen(out_cen), .inj_arm(inj_arm), .inj_mask(inj_mask),
        .inj_armed(inj_armed), .out_words(out_words), .inj_words(inj_words)
    );

    sec32_check_encoder #(.CNT_W(16), .INJ_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_check(out_check0), .out_cen(out_cen0), .inj_arm(inj_arm), .inj_mask(inj_mask),
        .inj_armed(inj_armed0), .out_words(out_words0), .inj_words(inj_words0)
    );

    int checks   = 0;
    int failures = 0;

    // Expected {check,data} queues: q1 for dut (with injection), q0 for dut0.
    logic [39:0] q1[$];
    logic [39:0] q0[$];
    logic [7:0]  exp_chk;
    logic [39:0] exp_mask;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock period, entered just after a falling edge with inputs set.
    task automatic cyc(output bit acc);
        logic [39:0] e;
        #2;
        acc = in_valid && in_ready;
        if (acc) begin
            q1.push_back({exp_chk, in_data} ^ exp_mask);
            q0.push_back({exp_chk, in_data});
        end
        if (out_valid && out_ready) begin
            if (q1.size() == 0) begin
                check_eq("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check_eq("codeword", {out_check, out_data}, e);
                check_eq("cen", out_cen, 1'b1);
            end
        end
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                check_eq("unexpected_out0", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                check_eq("codeword_noinj", {out_check0, out_data0}, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        bit a;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q1.size() != 0 || q0.size() != 0); i++) cyc(a);
        check_eq(tag, q1.size() + q0.size(), 0);
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] c, input logic [39:0] m);
        bit a;
        in_valid = 1'b1;
        in_data  = d;
        exp_chk  = c;
        exp_mask = m;
        cyc(a);
        in_valid = 1'b0;
        exp_mask = '0;
        if (!a) check_eq("send_accept", 64'd0, 64'd1);
    endtask

    task automatic arm(input logic [39:0] m);
        bit a;
        inj_arm  = 1'b1;
        inj_mask = m;
        cyc(a);
        inj_arm  = 1'b0;
    endtask

    // Hand-computed vectors: each single bit maps to the checks listing it.
    logic [31:0] vec_d [6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0001_0000,
                               32'h8000_0000, 32'h0000_0020, 32'h0000_0000};
    logic [7:0]  vec_c [6] = '{8'h51, 8'h00, 8'h15, 8'h8A, 8'h92, 8'h00};

    initial begin
        bit          a;
        int          nacc;
        logic [15:0] base;
        logic [31:0] w;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        inj_arm = 1'b0; inj_mask = '0; exp_chk = '0; exp_mask = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_cen", out_cen, 1'b0);
        check_eq("rst_out_cw", {out_check, out_data}, 40'h0);
        check_eq("rst_counters", {out_words, inj_words}, 32'h0);
        check_eq("rst_inj_armed", inj_armed, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Latency on the first word: not valid one edge after accept, valid after two.
        in_valid = 1'b1; in_data = vec_d[0]; exp_chk = vec_c[0]; exp_mask = '0;
        cyc(a);
        in_valid = 1'b0;
        check_eq("lat_accept", a, 1'b1);
        #1 check_eq("lat_n", out_valid, 1'b0);
        cyc(a);
        #1 check_eq("lat_n1", out_valid, 1'b1);
        drain("drain_first");
        for (int i = 1; i < 6; i++) begin
            send(vec_d[i], vec_c[i], '0);
        end
        drain("drain_vectors");
        #1 check_eq("words_vectors", out_words, 16'd6);

        // Streaming: 100 words back to back.
        base = out_words;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            in_data = w;
            exp_chk = sec32_check(w);
            cyc(a);
            if (!a) check_eq("stream_accept", 64'd0, 64'd1);
        end
        drain("drain_stream");
        #1 check_eq("words_stream", out_words - base, 16'd100);

        // Back-pressure: only two words fit.
        base = out_words;
        nacc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'hA500_0000 + nacc;
            exp_chk = sec32_check(in_data);
            cyc(a);
            if (a) nacc++;
        end
        #1;
        check_eq("bp_accepted", nacc, 2);
        check_eq("bp_in_ready", in_ready, 1'b0);
        check_eq("bp_out_valid", out_valid, 1'b1);
        drain("drain_bp");
        #1 check_eq("words_bp", out_words - base, 16'd2);

        // Injection: data bit 10 flipped on the next word only.
        arm(40'h00_0000_0400);
        #1;
        check_eq("inj_armed_set", inj_armed, 1'b1);
        check_eq("inj_armed_disabled", inj_armed0, 1'b0);
        send(32'h0000_0000, 8'h00, 40'h00_0000_0400);
        send(32'h0000_0001, 8'h51, '0);
        drain("drain_inj");
        #1;
        check_eq("inj_armed_clr", inj_armed, 1'b0);
        check_eq("inj_words_1", inj_words, 16'd1);

        // Re-arm while armed: only the last mask (check bit 7) applies.
        arm(40'h00_0000_0001);
        arm(40'h80_0000_0000);
        send(32'hFFFF_FFFF, 8'h00, 40'h80_0000_0000);
        send(32'hFFFF_FFFF, 8'h00, '0);
        drain("drain_rearm");
        #1 check_eq("inj_words_2", inj_words, 16'd2);

        // Arm coinciding with an S1->S2 move reaches the following word.
        in_valid = 1'b1; in_data = 32'h0000_0020; exp_chk = 8'h92; exp_mask = '0;
        cyc(a);
        inj_arm = 1'b1; inj_mask = 40'h00_0000_0002;
        in_data = 32'h0001_0000; exp_chk = 8'h15; exp_mask = 40'h00_0000_0002;
        cyc(a);
        inj_arm = 1'b0; exp_mask = '0;
        drain("drain_concurrent");
        #1;
        check_eq("inj_words_3", inj_words, 16'd3);
        check_eq("inj_words_disabled", inj_words0, 16'd0);

        // Reset in the middle of a stall with an armed mask.
        arm(40'h00_0000_0010);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
        exp_chk = sec32_check(in_data);
        cyc(a);
        cyc(a);
        #3 rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_armed", inj_armed, 1'b0);
        check_eq("mid_rst_counters", {out_words, inj_words}, 32'h0);
        check_eq("mid_rst_cw", {out_check, out_data}, 40'h0);
        q1.delete();
        q0.delete();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rel_in_ready", in_ready, 1'b1);
        check_eq("mid_rel_out_valid", out_valid, 1'b0);
        @(negedge clk);
        send(32'h8000_0000, 8'h8A, '0);
        drain("drain_after_rst");
        #1 check_eq("words_after_rst", out_words, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
